// File: rtl/fu_issue_ctrl.sv
// rtl/fu_issue_ctrl.sv - initiator side of the mul/div functional-unit interface
//
// Takes one instruction from reservation-station select, launches it into the
// mul/div unit, waits for completion (or timeout) and holds the result on the
// common data bus until the arbiter grants it.
//
// Ports:
//   clk, rst (sync, active-low), flush
//   iss_*   : issue handshake and operands from the reservation station
//   fu_*    : start strobe, operands and tags to the unit; done/result back
//   cdb_*   : result request, tags, value and error flag; grant from arbiter
//   busy    : block is not idle
module fu_issue_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [DATA_W-1:0] iss_a,
   input  logic [DATA_W-1:0] iss_b,
   input  logic [3:0]        iss_op,
   input  logic [TAG_W-1:0]  iss_rs,
   input  logic [TAG_W-1:0]  iss_rob,
   output logic              fu_data_ready,
   output logic [DATA_W-1:0] fu_x,
   output logic [DATA_W-1:0] fu_y,
   output logic [3:0]        fu_ctrl,
   output logic [TAG_W-1:0]  fu_save_no,
   output logic [TAG_W-1:0]  fu_rd_rob,
   input  logic              fu_done,
   input  logic [DATA_W-1:0] fu_result,
   output logic              cdb_valid,
   input  logic              cdb_grant,
   output logic [TAG_W-1:0]  cdb_rs,
   output logic [TAG_W-1:0]  cdb_rob,
   output logic [DATA_W-1:0] cdb_value,
   output logic              cdb_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_BCAST
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [3:0]          op_q, op_d;
   logic [TAG_W-1:0]    rs_q, rs_d;
   logic [TAG_W-1:0]    rob_q, rob_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept;
   logic                op_ok;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      rs_d      = rs_q;
      rob_d     = rob_q;
      value_d   = value_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      iss_ready = 1'b0;
      op_ok     = (iss_op == 4'b0010) || (iss_op == 4'b0011);

      // A new op may enter from IDLE, or in the grant cycle of a broadcast.
      if (rst) begin
         case (state_q)
            S_IDLE:  iss_ready = !flush;
            S_BCAST: iss_ready = cdb_grant && !flush;
            default: iss_ready = 1'b0;
         endcase
      end
      accept = iss_valid && iss_ready;

      case (state_q)
         S_LAUNCH: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // cnt_q == 0 is the first WAIT cycle: the divider's done is still
            // stale-high there, so it is not trusted. Done beats timeout.
            if (fu_done && (cnt_q != '0)) begin
               state_d = S_BCAST;
               value_d = fu_result;
               err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_BCAST;
               value_d = '0;
               err_d   = 1'b1;
            end
         end
         S_BCAST: begin
            if (cdb_grant) state_d = S_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         a_d   = iss_a;
         b_d   = iss_b;
         op_d  = iss_op;
         rs_d  = iss_rs;
         rob_d = iss_rob;
         if (op_ok) begin
            state_d = S_LAUNCH;
         end else begin
            // Unsupported opcode never reaches the unit; report it directly.
            state_d = S_BCAST;
            value_d = '0;
            err_d   = 1'b1;
         end
      end

      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rs_q    <= '0;
         rob_q   <= '0;
         value_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rob_q   <= rob_d;
         value_q <= value_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand latches only change on accept, so the unit sees stable inputs
   // for the whole of WAIT and the CDB sees stable tags for the whole of BCAST.
   assign fu_data_ready = (state_q == S_LAUNCH);
   assign fu_x          = a_q;
   assign fu_y          = b_q;
   assign fu_ctrl       = op_q;
   assign fu_save_no    = rs_q;
   assign fu_rd_rob     = rob_q;
   assign cdb_valid     = (state_q == S_BCAST);
   assign cdb_rs        = rs_q;
   assign cdb_rob       = rob_q;
   assign cdb_value     = value_q;
   assign cdb_err       = err_q;
   assign busy          = rst && (state_q != S_IDLE);

endmodule

// File: doc/fu_issue_ctrl.md
Name: fu_issue_ctrl

Overview:
- Initiator side of the mul/div functional-unit interface.
- Accepts one ready instruction at a time from the reservation-station select logic and launches it into the functional unit (operands, ctrl, station number, ROB tag, start strobe).
- Waits for the unit's completion, captures the result, and broadcasts it on the common data bus (CDB) until the CDB arbiter grants it.
- Also handles unsupported opcodes, timeout and pipeline flush.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 5, width of the reservation-station number and ROB tag
- TIMEOUT, 64, max WAIT cycles without fu_done before an error broadcast (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  squash the in-flight op (branch mispredict / exception)
- iss_valid  in  1  instruction offered by the reservation station
- iss_ready  out  1  this block accepts the offer this cycle
- iss_a  in  DATA_W  operand A
- iss_b  in  DATA_W  operand B
- iss_op  in  4  function code: 0010 = mul, 0011 = div
- iss_rs  in  TAG_W  reservation-station number
- iss_rob  in  TAG_W  destination ROB tag
- fu_data_ready  out  1  one-cycle start strobe to the unit
- fu_x  out  DATA_W  operand A to the unit
- fu_y  out  DATA_W  operand B to the unit
- fu_ctrl  out  4  function code to the unit
- fu_save_no  out  TAG_W  station number to the unit
- fu_rd_rob  out  TAG_W  ROB tag to the unit
- fu_done  in  1  unit completion flag
- fu_result  in  DATA_W  unit result
- cdb_valid  out  1  result request on the CDB
- cdb_grant  in  1  CDB arbiter accepts this block's result
- cdb_rs  out  TAG_W  station freed by the broadcast
- cdb_rob  out  TAG_W  ROB entry written by the broadcast
- cdb_value  out  DATA_W  broadcast value
- cdb_err  out  1  result invalid (bad opcode or timeout)
- busy  out  1  state != IDLE

Behaviour:

Reset:
- rst low at a clock edge puts the block in IDLE and clears all registered outputs to 0 (fu_*, cdb_*, timeout counter).
- iss_ready = 0 and busy = 0 while rst is low.
- Reset mid-operation abandons the op; no broadcast is made.

States:
- IDLE
  - iss_ready = !flush.
  - On iss_valid & iss_ready, latch a, b, op, rs, rob.
  - Next state is LAUNCH if op is 0010 or 0011, otherwise BCAST with cdb_err = 1 and cdb_value = 0.
- LAUNCH (exactly 1 cycle)
  - fu_data_ready = 1; fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob driven from the latches.
  - Next state: WAIT; timeout counter cleared.
- WAIT
  - fu_data_ready = 0.
  - fu_x, fu_y, fu_ctrl, fu_save_no and fu_rd_rob stay stable for the whole of WAIT.
  - fu_done is ignored in the first WAIT cycle, because the divider reports done as !busy and reads stale-high before it starts.
  - From the second WAIT cycle on, fu_done = 1 captures fu_result into cdb_value, sets cdb_err = 0, and moves to BCAST.
  - Counter increments each WAIT cycle. If it reaches TIMEOUT with no done, move to BCAST with cdb_err = 1 and cdb_value = 0.
  - fu_done and timeout in the same cycle: done wins.
- BCAST
  - cdb_valid = 1; cdb_rs, cdb_rob, cdb_value and cdb_err held stable until cdb_grant.
  - On cdb_grant, cdb_valid drops next cycle.
  - iss_ready = cdb_grant & !flush, so a new op may be accepted in the grant cycle (back-to-back). If accepted, go to LAUNCH (or BCAST for a bad op); otherwise go to IDLE.

Flush:
- In any state, flush = 1 forces IDLE at the next edge.
- cdb_valid is 0 from that next cycle and no broadcast completes.
- A flush in the grant cycle still counts the grant as done.
- No issue is accepted in a flush cycle.

Latency:
- Accept at cycle T; fu_data_ready at T+1; earliest fu_done sample at T+3; earliest cdb_valid at T+4.
- cdb_valid stays high as long as cdb_grant is low.

Width rules: fu_result is passed through unmodified; no sign or width conversion.

Test Plan:
- mul: issue a=7, b=6, op=0010, rs=3, rob=9; model raises fu_done 3 cycles after the strobe with 42 -> exactly one fu_data_ready pulse; then cdb_valid=1, cdb_value=42, cdb_rs=3, cdb_rob=9, cdb_err=0.
- div with stale done: fu_done=1 before start and in the first WAIT cycle, real result 14 (100/7) two cycles later -> the first-WAIT-cycle done is ignored; cdb_value=14.
- Bad op and timeout: op=0001 -> no fu_data_ready, cdb_err=1, value 0. Separately, op=0011 with fu_done stuck 0 -> cdb_err=1 after exactly 64 WAIT cycles.
- CDB backpressure and back-to-back: cdb_grant low 5 cycles -> cdb outputs stable for all 5. Then grant with iss_valid high -> new op accepted in the grant cycle and fu_data_ready on the next cycle.
- Flush: flush in the second WAIT cycle -> IDLE next cycle, busy=0, no cdb_valid, a later fu_done is ignored.
- Reset mid-BCAST: rst=0 for 1 cycle while cdb_valid=1 -> all outputs 0, IDLE; the next issue proceeds normally.
